// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the pipelined MIPS core.
// Opcodes, ALU op encoding and the control word carried down the pipe.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_NOP   = 6'b111111;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_SLT  = 4'b0111,
    ALU_MULT = 4'b1000,
    ALU_DIV  = 4'b1001
  } alu_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic    reg_dst;
    logic    jump;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    beq;
    logic    bne;
    logic    illegal;
    alu_op_e alu_op;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_ZERO = '0;

  function automatic logic is_muldiv(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    return (op == OP_RTYPE) &&
           ((fn == FN_MULT) || (fn == FN_DIV));
  endfunction

  // Anything that writes or reads HI/LO must wait for the unit.
  function automatic logic uses_hilo(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    return is_muldiv(op, fn) ||
           ((op == OP_RTYPE) &&
            ((fn == FN_MFHI) || (fn == FN_MFLO)));
  endfunction

endpackage

// File: rtl/pipe_ctrl_decode_muldiv_seq.sv
// IDLE/BUSY sequencer for the multi-cycle multiplier/divider.
// Counts down MULDIV_LAT busy cycles after each accepted launch.
module muldiv_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic start_pulse
);

  localparam int CW = $clog2(MULDIV_LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MULDIV_LAT - 1);

  md_state_e       state;
  md_state_e       state_nx;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nx;
  logic            pulse_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= MD_IDLE;
      cnt         <= '0;
      start_pulse <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      start_pulse <= pulse_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pulse_nx = 1'b0;
    unique case (state)
      MD_IDLE: begin
        if (start) begin
          state_nx = MD_BUSY;
          cnt_nx   = CNT_LOAD;
          pulse_nx = 1'b1;
        end
      end
      MD_BUSY: begin
        if (cnt == '0) begin
          state_nx = MD_IDLE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = MD_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == MD_BUSY);
  end

endmodule

// File: rtl/pipe_ctrl_decode.sv
// ID-stage control decode and ID/EX control register.
// Also launches MULT/DIV and holds IF/ID while HI/LO is pending.
module pipe_ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int ALU_OP_W   = 4,
  parameter int MULDIV_LAT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                stall_in,
  input  logic                flush,
  output logic                id_stall,
  output logic                ex_valid,
  output logic                ex_reg_dst,
  output logic                ex_jump,
  output logic                ex_alu_src,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_reg_write,
  output logic                ex_beq,
  output logic                ex_bne,
  output logic                ex_illegal,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                md_start,
  output logic                md_busy
);

  function automatic ctrl_word_t decode(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    ctrl_word_t w;
    w = CTRL_ZERO;
    unique case (1'b1)
      op == OP_RTYPE: begin
        w.reg_dst   = 1'b1;
        w.reg_write = 1'b1;
        unique case (1'b1)
          fn == FN_ADD,
          fn == FN_MFHI,
          fn == FN_MFLO: w.alu_op = ALU_ADD;
          fn == FN_SUB:  w.alu_op = ALU_SUB;
          fn == FN_AND:  w.alu_op = ALU_AND;
          fn == FN_OR:   w.alu_op = ALU_OR;
          fn == FN_SLT:  w.alu_op = ALU_SLT;
          fn == FN_MULT: begin
            w.alu_op    = ALU_MULT;
            w.reg_write = 1'b0;
          end
          fn == FN_DIV: begin
            w.alu_op    = ALU_DIV;
            w.reg_write = 1'b0;
          end
          default: begin
            w         = CTRL_ZERO;
            w.illegal = 1'b1;
          end
        endcase
      end
      op == OP_ADDI: begin
        w.alu_src   = 1'b1;
        w.reg_write = 1'b1;
      end
      op == OP_ANDI: begin
        w.alu_op    = ALU_AND;
        w.alu_src   = 1'b1;
        w.reg_write = 1'b1;
      end
      op == OP_ORI: begin
        w.alu_op    = ALU_OR;
        w.alu_src   = 1'b1;
        w.reg_write = 1'b1;
      end
      op == OP_SLTI: begin
        w.alu_op    = ALU_SLT;
        w.alu_src   = 1'b1;
        w.reg_write = 1'b1;
      end
      op == OP_LW: begin
        w.alu_src   = 1'b1;
        w.mem_read  = 1'b1;
        w.reg_write = 1'b1;
      end
      op == OP_SW: begin
        w.alu_src   = 1'b1;
        w.mem_write = 1'b1;
      end
      op == OP_BEQ: begin
        w.alu_op = ALU_SUB;
        w.beq    = 1'b1;
      end
      op == OP_BNE: begin
        w.alu_op = ALU_SUB;
        w.bne    = 1'b1;
      end
      op == OP_J:   w.jump = 1'b1;
      op == OP_NOP: w = CTRL_ZERO;
      default:      w.illegal = 1'b1;
    endcase
    return w;
  endfunction

  ctrl_word_t dec;
  ctrl_word_t ex_q;
  logic       load;
  logic       md_go;

  assign dec      = decode(opcode, funct);
  assign id_stall = id_valid & md_busy & uses_hilo(opcode, funct);
  assign load     = ~flush & ~stall_in & ~id_stall;
  assign md_go    = load & id_valid & is_muldiv(opcode, funct);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_q     <= CTRL_ZERO;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_q     <= CTRL_ZERO;
    end else if (!stall_in) begin
      if (id_stall) begin
        ex_valid <= 1'b0;
        ex_q     <= CTRL_ZERO;
      end else begin
        ex_valid <= id_valid;
        ex_q     <= dec;
      end
    end
  end

  muldiv_seq #(
    .MULDIV_LAT (MULDIV_LAT)
  ) u_muldiv_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (md_go),
    .busy        (md_busy),
    .start_pulse (md_start)
  );

  assign ex_reg_dst   = ex_q.reg_dst;
  assign ex_jump      = ex_q.jump;
  assign ex_alu_src   = ex_q.alu_src;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_beq       = ex_q.beq;
  assign ex_bne       = ex_q.bne;
  assign ex_illegal   = ex_q.illegal;
  assign ex_alu_op    = ALU_OP_W'(ex_q.alu_op);

endmodule

// File: tb/tb_pipe_ctrl_decode.sv
// Bench for pipe_ctrl_decode: directed scenarios plus random traffic
// checked against an instruction-level model of decode and HI/LO busy.
module tb_pipe_ctrl_decode;

  localparam int LAT = 4;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       stall_in;
  logic       flush;
  logic       id_stall;
  logic       ex_valid;
  logic       ex_reg_dst, ex_jump, ex_alu_src, ex_mem_read;
  logic       ex_mem_write, ex_reg_write, ex_beq, ex_bne, ex_illegal;
  logic [3:0] ex_alu_op;
  logic       md_start;
  logic       md_busy;
  logic [12:0] dut_word;

  pipe_ctrl_decode #(
    .ALU_OP_W   (4),
    .MULDIV_LAT (LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .opcode       (opcode),
    .funct        (funct),
    .stall_in     (stall_in),
    .flush        (flush),
    .id_stall     (id_stall),
    .ex_valid     (ex_valid),
    .ex_reg_dst   (ex_reg_dst),
    .ex_jump      (ex_jump),
    .ex_alu_src   (ex_alu_src),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_reg_write (ex_reg_write),
    .ex_beq       (ex_beq),
    .ex_bne       (ex_bne),
    .ex_illegal   (ex_illegal),
    .ex_alu_op    (ex_alu_op),
    .md_start     (md_start),
    .md_busy      (md_busy)
  );

  assign dut_word = {ex_reg_dst, ex_jump, ex_alu_src, ex_mem_read,
                     ex_mem_write, ex_reg_write, ex_beq, ex_bne,
                     ex_illegal, ex_alu_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic        m_valid;
  logic [12:0] m_word;
  logic        m_known;
  logic        m_start;
  int          m_busy;
  logic        last_stall;

  function automatic logic [12:0] f(
    input logic rd, j, as, mr, mw, rw, b, bn, ill,
    input logic [3:0] alu
  );
    return {rd, j, as, mr, mw, rw, b, bn, ill, alu};
  endfunction

  function automatic logic [12:0] ref_decode(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    logic [12:0] ill;
    ill = f(0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd0);
    case (op)
      6'b000000:
        case (fn)
          6'b100000, 6'b010000, 6'b010010:
                     return f(1, 0, 0, 0, 0, 1, 0, 0, 0, 4'd0);
          6'b100010: return f(1, 0, 0, 0, 0, 1, 0, 0, 0, 4'd1);
          6'b100100: return f(1, 0, 0, 0, 0, 1, 0, 0, 0, 4'd2);
          6'b100101: return f(1, 0, 0, 0, 0, 1, 0, 0, 0, 4'd3);
          6'b101010: return f(1, 0, 0, 0, 0, 1, 0, 0, 0, 4'd7);
          6'b011000: return f(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd8);
          6'b011010: return f(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd9);
          default:   return ill;
        endcase
      6'b001000: return f(0, 0, 1, 0, 0, 1, 0, 0, 0, 4'd0);
      6'b001100: return f(0, 0, 1, 0, 0, 1, 0, 0, 0, 4'd2);
      6'b001101: return f(0, 0, 1, 0, 0, 1, 0, 0, 0, 4'd3);
      6'b001010: return f(0, 0, 1, 0, 0, 1, 0, 0, 0, 4'd7);
      6'b100011: return f(0, 0, 1, 1, 0, 1, 0, 0, 0, 4'd0);
      6'b101011: return f(0, 0, 1, 0, 1, 0, 0, 0, 0, 4'd0);
      6'b000100: return f(0, 0, 0, 0, 0, 0, 1, 0, 0, 4'd1);
      6'b000101: return f(0, 0, 0, 0, 0, 0, 0, 1, 0, 4'd1);
      6'b000010: return f(0, 1, 0, 0, 0, 0, 0, 0, 0, 4'd0);
      6'b111111: return 13'd0;
      default:   return ill;
    endcase
  endfunction

  function automatic logic ref_md(input logic [5:0] op, input logic [5:0] fn);
    return op == 6'd0 && (fn == 6'b011000 || fn == 6'b011010);
  endfunction

  function automatic logic ref_dep(input logic [5:0] op, input logic [5:0] fn);
    return ref_md(op, fn) ||
           (op == 6'd0 && (fn == 6'b010000 || fn == 6'b010010));
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_word  = 13'd0;
    m_known = 1'b1;
    m_start = 1'b0;
    m_busy  = 0;
  endtask

  task automatic step(
    input logic v, input logic [5:0] op, input logic [5:0] fn,
    input logic st, input logic fl
  );
    logic dep, start;
    id_valid = v;
    opcode   = op;
    funct    = fn;
    stall_in = st;
    flush    = fl;
    #1;
    dep = v && (m_busy > 0) && ref_dep(op, fn);
    last_stall = id_stall;
    total++;
    if (id_stall !== dep) begin
      bad++;
      $display("FAIL id_stall op=%b fn=%b got=%b want=%b", op, fn, id_stall, dep);
    end
    start = v && ref_md(op, fn) && !fl && !st && !dep;
    if (fl) begin
      m_valid = 1'b0;
      m_word  = 13'd0;
      m_known = 1'b1;
    end else if (st) begin
    end else if (dep) begin
      m_valid = 1'b0;
      m_known = 1'b0;
    end else begin
      m_valid = v;
      m_word  = ref_decode(op, fn);
      m_known = 1'b1;
    end
    m_start = start;
    m_busy  = start ? LAT : (m_busy > 0 ? m_busy - 1 : 0);
    @(posedge clk);
    #1;
    total++;
    if (ex_valid !== m_valid) begin
      bad++;
      $display("FAIL ex_valid got=%b want=%b", ex_valid, m_valid);
    end
    if (m_known) begin
      total++;
      if (dut_word !== m_word) begin
        bad++;
        $display("FAIL ex_word got=%h want=%h", dut_word, m_word);
      end
    end
    total++;
    if (md_start !== m_start) begin
      bad++;
      $display("FAIL md_start got=%b want=%b", md_start, m_start);
    end
    total++;
    if (md_busy !== (m_busy > 0)) begin
      bad++;
      $display("FAIL md_busy got=%b want=%b", md_busy, m_busy > 0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    id_valid = 1'b0; opcode = 6'd0; funct = 6'd0;
    stall_in = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({ex_valid, dut_word, md_start, md_busy} !== 16'd0) begin
      bad++;
      $display("FAIL reset_state got=%h want=0",
               {ex_valid, dut_word, md_start, md_busy});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_addi_lw();
    step(1, 6'b001000, 6'd0, 0, 0);
    total++;
    if (ex_alu_op !== 4'd0 || ex_alu_src !== 1'b1) begin
      bad++;
      $display("FAIL addi got=%h/%b want=0/1", ex_alu_op, ex_alu_src);
    end
    step(1, 6'b100011, 6'd0, 0, 0);
    total++;
    if (ex_mem_read !== 1'b1) begin
      bad++;
      $display("FAIL lw_mem_read got=%b want=1", ex_mem_read);
    end
  endtask

  task automatic test_slt();
    step(1, 6'b000000, 6'b101010, 0, 0);
    total++;
    if (ex_alu_op !== 4'd7 || ex_reg_dst !== 1'b1) begin
      bad++;
      $display("FAIL slt got=%h/%b want=7/1", ex_alu_op, ex_reg_dst);
    end
    step(1, 6'b001010, 6'd0, 0, 0);
    total++;
    if (ex_alu_op !== 4'd7 || ex_reg_dst !== 1'b0) begin
      bad++;
      $display("FAIL slti got=%h/%b want=7/0", ex_alu_op, ex_reg_dst);
    end
  endtask

  task automatic test_illegal();
    step(1, 6'b010111, 6'd0, 0, 0);
    total++;
    if (ex_valid !== 1'b1 || dut_word !== 13'h010) begin
      bad++;
      $display("FAIL illegal_op got=%b/%h want=1/010", ex_valid, dut_word);
    end
    step(1, 6'b000000, 6'b111000, 0, 0);
    total++;
    if (ex_valid !== 1'b1 || dut_word !== 13'h010) begin
      bad++;
      $display("FAIL illegal_fn got=%b/%h want=1/010", ex_valid, dut_word);
    end
  endtask

  task automatic test_mult_mflo();
    int stalls;
    int waited;
    stalls = 0;
    waited = 0;
    step(1, 6'b000000, 6'b011000, 0, 0);
    total++;
    if (md_start !== 1'b1 || ex_alu_op !== 4'd8) begin
      bad++;
      $display("FAIL mult_start got=%b/%h want=1/8", md_start, ex_alu_op);
    end
    do begin
      step(1, 6'b000000, 6'b010010, 0, 0);
      if (last_stall === 1'b1) stalls++;
      waited++;
    end while (last_stall === 1'b1 && waited < 20);
    total++;
    if (stalls != LAT) begin
      bad++;
      $display("FAIL mflo_stall_cycles got=%0d want=%0d", stalls, LAT);
    end
    total++;
    if (ex_valid !== 1'b1 || ex_reg_dst !== 1'b1 || md_busy !== 1'b0) begin
      bad++;
      $display("FAIL mflo_enter got=%b%b%b want=110", ex_valid, ex_reg_dst, md_busy);
    end
  endtask

  task automatic test_hold_bubble();
    step(1, 6'b001000, 6'd0, 0, 0);
    repeat (2) begin
      step(1, 6'b101011, 6'd0, 1, 0);
      total++;
      if (ex_mem_write !== 1'b0 || ex_reg_write !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold got=%b%b want=01", ex_mem_write, ex_reg_write);
      end
    end
    step(1, 6'b101011, 6'd0, 1, 1);
    total++;
    if (ex_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_stall got=%b want=0", ex_valid);
    end
    step(1, 6'b000000, 6'b011010, 0, 1);
    total++;
    if (md_start !== 1'b0 || md_busy !== 1'b0) begin
      bad++;
      $display("FAIL flush_div got=%b%b want=00", md_start, md_busy);
    end
  endtask

  task automatic test_reset_mid_busy();
    step(1, 6'b000000, 6'b011010, 0, 0);
    step(1, 6'b001101, 6'd0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({ex_valid, dut_word, md_start, md_busy} !== 16'd0) begin
      bad++;
      $display("FAIL async_reset got=%h want=0",
               {ex_valid, dut_word, md_start, md_busy});
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 6'b000000, 6'b010000, 0, 0);
    total++;
    if (md_busy !== 1'b0 || ex_valid !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_idle got=%b%b want=01", md_busy, ex_valid);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [12];
    logic [5:0] fns [10];
    logic [5:0] op, fn;
    ops = '{6'd0, 6'd8, 6'd12, 6'd13, 6'd10, 6'd35, 6'd43,
            6'd4, 6'd5, 6'd2, 6'd63, 6'd0};
    fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd24, 6'd26,
            6'd16, 6'd18, 6'd0};
    for (int i = 0; i < 500; i++) begin
      op = ops[$urandom_range(11)];
      fn = fns[$urandom_range(9)];
      if ($urandom_range(15) == 0) op = 6'($urandom);
      if ($urandom_range(15) == 0) fn = 6'($urandom);
      step($urandom_range(7) != 0, op, fn,
           $urandom_range(7) == 0, $urandom_range(9) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_addi_lw();
    test_slt();
    test_illegal();
    test_mult_mflo();
    test_hold_bubble();
    test_reset_mid_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
